// File: rtl/led_meter_pkg.sv
// Shared constants for the LED meter engine: display modes and FSM states.
package led_meter_pkg;

  localparam logic [1:0] MODE_BIPOLAR  = 2'd0;
  localparam logic [1:0] MODE_UNIPOLAR = 2'd1;
  localparam logic [1:0] MODE_DOT      = 2'd2;
  localparam logic [1:0] MODE_MIRROR   = 2'd3;

  // state    | meaning
  // ST_IDLE  | outputs quiet, waiting for pos_valid
  // ST_SHIFT | clocking the frame out MSB first, one bit per 2*CLK_DIV cycles
  // ST_LATCH | led_clk low, le high for CLK_DIV cycles; frame_done on the last
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/led_pattern_render.sv
// Combinational renderer: position + display mode -> one bit per LED.
module led_pattern_render
  import led_meter_pkg::*;
#(
  parameter int N_LEDS = 16,
  parameter int POS_W  = 6,
  parameter int CENTER = 18
) (
  input  logic [POS_W-1:0]  pos_i,
  input  logic [1:0]        mode_i,
  output logic [N_LEDS-1:0] pattern_o
);

  // One spare bit so pos - CENTER and CENTER - pos never wrap.
  localparam int KW = POS_W + 1;
  localparam logic [KW-1:0] CTR = KW'(CENTER);
  localparam int HALF = N_LEDS / 2;

  logic [KW-1:0] pos_x;
  logic [KW-1:0] k_raw;
  logic          above;
  int            kn;

  // Lit-bit count k per mode, saturated at N_LEDS, then expanded to a bit mask.
  always_comb begin
    pos_x     = {1'b0, pos_i};
    above     = (pos_x > CTR);
    k_raw     = '0;
    pattern_o = '0;
    case (mode_i)
      MODE_BIPOLAR:  k_raw = above ? (pos_x - CTR) : (CTR - pos_x);
      MODE_UNIPOLAR: k_raw = pos_x;
      MODE_MIRROR:   k_raw = (int'(pos_x) > HALF) ? KW'(HALF) : pos_x;
      default:       k_raw = '0;
    endcase
    kn = (int'(k_raw) > N_LEDS) ? N_LEDS : int'(k_raw);
    for (int i = 0; i < N_LEDS; i++) begin
      case (mode_i)
        MODE_BIPOLAR:  pattern_o[i] = above ? (i < kn) : (i >= N_LEDS - kn);
        MODE_UNIPOLAR: pattern_o[i] = (i < kn);
        MODE_DOT:      pattern_o[i] = (int'(pos_x) == i);
        default:       pattern_o[i] = (i >= HALF - kn) && (i < HALF + kn);
      endcase
    end
  end

endmodule

// File: rtl/led_meter_driver.sv
// LED meter engine: renders a position into an N-LED frame, shifts it into a
// chain of constant-current drivers, latches it and PWM-dims via oe.
module led_meter_driver
  import led_meter_pkg::*;
#(
  parameter int N_LEDS  = 16,
  parameter int POS_W   = 6,
  parameter int CENTER  = 18,
  parameter int CLK_DIV = 4,
  parameter int PWM_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pos_valid,
  input  logic [POS_W-1:0] pos,
  input  logic [1:0]       mode,
  input  logic [PWM_W-1:0] brightness,
  output logic             busy,
  output logic             frame_done,
  output logic             led_clk,
  output logic             sdi,
  output logic             le,
  output logic             oe
);

  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(N_LEDS);
  localparam logic [PH_W-1:0]  PH_BIT   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LATCH = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_LEDS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [PWM_W-1:0] PWM_ONE  = PWM_W'(1);

  state_e             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [N_LEDS-1:0]  shift_q, shift_d;
  logic [PWM_W-1:0]   frm_bright_q, frm_bright_d;
  logic               pend_q, pend_d;
  logic [POS_W-1:0]   pend_pos_q, pend_pos_d;
  logic [1:0]         pend_mode_q, pend_mode_d;
  logic [PWM_W-1:0]   pend_bright_q, pend_bright_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               led_clk_q, led_clk_d;
  logic               le_q, le_d;
  logic [PWM_W-1:0]   cnt_q;
  logic [PWM_W-1:0]   bright_act_q;
  logic               oe_en_q;
  logic               oe_q;
  logic               start;
  logic [POS_W-1:0]   r_pos;
  logic [1:0]         r_mode;
  logic [N_LEDS-1:0]  pattern;

  // A fresh request always wins over the pending slot (latest wins).
  assign r_pos  = pos_valid ? pos  : pend_pos_q;
  assign r_mode = pos_valid ? mode : pend_mode_q;

  led_pattern_render #(
    .N_LEDS (N_LEDS),
    .POS_W  (POS_W),
    .CENTER (CENTER)
  ) u_render (
    .pos_i     (r_pos),
    .mode_i    (r_mode),
    .pattern_o (pattern)
  );

  // Next-state logic: phase/bit down-counters, pending slot, registered pin values.
  always_comb begin
    state_d       = state_q;
    ph_d          = ph_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    frm_bright_d  = frm_bright_q;
    pend_d        = pend_q;
    pend_pos_d    = pend_pos_q;
    pend_mode_d   = pend_mode_q;
    pend_bright_d = pend_bright_q;
    start         = 1'b0;
    case (state_q)
      ST_IDLE: start = pos_valid;
      ST_SHIFT: begin
        if (ph_q == '0) begin
          shift_d = shift_q << 1;
          if (bit_q == '0) begin
            state_d = ST_LATCH;
            ph_d    = PH_LATCH;
          end else begin
            bit_d = bit_q - BIT_ONE;
            ph_d  = PH_BIT;
          end
        end else begin
          ph_d = ph_q - PH_ONE;
        end
      end
      ST_LATCH: begin
        if (ph_q == '0) begin
          if (pos_valid || pend_q) start = 1'b1;
          else                     state_d = ST_IDLE;
        end else begin
          ph_d = ph_q - PH_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pos_valid && !start && state_q != ST_IDLE) begin
      pend_d        = 1'b1;
      pend_pos_d    = pos;
      pend_mode_d   = mode;
      pend_bright_d = brightness;
    end
    if (start) begin
      state_d      = ST_SHIFT;
      ph_d         = PH_BIT;
      bit_d        = BIT_LAST;
      shift_d      = pattern;
      frm_bright_d = pos_valid ? brightness : pend_bright_q;
      pend_d       = 1'b0;
    end
    busy_d       = (state_d != ST_IDLE);
    led_clk_d    = (state_d == ST_SHIFT) && (ph_d < PH_HALF);
    le_d         = (state_d == ST_LATCH);
    frame_done_d = (state_d == ST_LATCH) && (ph_d == '0);
  end

  // Frame engine registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ph_q          <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      frm_bright_q  <= '0;
      pend_q        <= 1'b0;
      pend_pos_q    <= '0;
      pend_mode_q   <= '0;
      pend_bright_q <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      led_clk_q     <= 1'b0;
      le_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      frm_bright_q  <= frm_bright_d;
      pend_q        <= pend_d;
      pend_pos_q    <= pend_pos_d;
      pend_mode_q   <= pend_mode_d;
      pend_bright_q <= pend_bright_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      led_clk_q     <= led_clk_d;
      le_q          <= le_d;
    end
  end

  // PWM dimming: brightness of a frame takes over once that frame is latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      bright_act_q <= '0;
      oe_en_q      <= 1'b0;
      oe_q         <= 1'b1;
    end else begin
      cnt_q <= cnt_q + PWM_ONE;
      if (frame_done_q) begin
        bright_act_q <= frm_bright_q;
        oe_en_q      <= 1'b1;
      end
      oe_q <= !(oe_en_q && (cnt_q < bright_act_q));
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign led_clk    = led_clk_q;
  assign sdi        = shift_q[N_LEDS-1];
  assign le         = le_q;
  assign oe         = oe_q;

endmodule

// File: tb/tb_led_meter_driver.sv
// Randomized + directed bench for led_meter_driver against a behavioural model.
module tb_led_meter_driver;

  localparam int N      = 16;
  localparam int POS_W  = 6;
  localparam int CENTER = 18;
  localparam int CDIV   = 2;
  localparam int PWM_W  = 4;
  localparam int FRAME_LEN = 2 * CDIV * N + CDIV;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pos_valid = 1'b0;
  logic [POS_W-1:0] pos = '0;
  logic [1:0]       mode = '0;
  logic [PWM_W-1:0] brightness = '0;
  logic             busy, frame_done, led_clk, sdi, le, oe;

  led_meter_driver #(
    .N_LEDS (N), .POS_W (POS_W), .CENTER (CENTER), .CLK_DIV (CDIV), .PWM_W (PWM_W)
  ) dut (
    .clk (clk), .rst (rst), .pos_valid (pos_valid), .pos (pos), .mode (mode),
    .brightness (brightness), .busy (busy), .frame_done (frame_done),
    .led_clk (led_clk), .sdi (sdi), .le (le), .oe (oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: lit-count arithmetic turned straight into masks.
  function automatic logic [N-1:0] ref_pattern(input int p, input int m);
    int k;
    longint unsigned ones;
    case (m)
      0: begin
        k = (p > CENTER) ? p - CENTER : CENTER - p;
        if (k > N) k = N;
        ones = (64'd1 << k) - 1;
        return (p > CENTER) ? N'(ones) : N'(ones << (N - k));
      end
      1: begin
        k = (p > N) ? N : p;
        return N'((64'd1 << k) - 1);
      end
      2: return (p < N) ? N'(64'd1 << p) : '0;
      default: begin
        k = (p > N / 2) ? N / 2 : p;
        return N'(((64'd1 << (2 * k)) - 1) << (N / 2 - k));
      end
    endcase
  endfunction

  typedef struct {
    logic [N-1:0] bits;
    int rises;
    int le_cycles;
    int fd_cyc;
    int first_rise;
  } frame_t;

  frame_t fq[$];
  logic [N-1:0] mon_bits;
  int mon_rises, mon_le, mon_first;
  int le_total = 0, sdi_glitch = 0, oe_early = 0, idle_cnt = 0, le_clk_overlap = 0;
  logic prev_clk = 1'b0, rise_sdi = 1'b0, fd_seen = 1'b0;

  // Pin monitor: reassembles frames from led_clk rises and watches protocol rules.
  always @(negedge clk) begin
    if (rst) begin
      mon_bits = '0; mon_rises = 0; mon_le = 0; mon_first = -1; fd_seen = 1'b0;
    end else begin
      if (led_clk && !prev_clk) begin
        mon_bits = {mon_bits[N-2:0], sdi};
        if (mon_rises == 0) mon_first = cyc;
        mon_rises++;
        rise_sdi = sdi;
      end else if (led_clk && prev_clk && sdi !== rise_sdi) begin
        sdi_glitch++;
      end
      if (le) begin mon_le++; le_total++; end
      if (le && led_clk) le_clk_overlap++;
      if (!fd_seen && !oe) oe_early++;
      if (!busy) idle_cnt++;
      if (frame_done) begin
        fq.push_back('{mon_bits, mon_rises, mon_le, cyc, mon_first});
        mon_bits = '0; mon_rises = 0; mon_le = 0; mon_first = -1;
        fd_seen = 1'b1;
      end
    end
    prev_clk = led_clk;
  end

  int t_send;

  task automatic send(input int p, input int m, input int b);
    @(posedge clk); #1;
    pos = POS_W'(p); mode = 2'(m); brightness = PWM_W'(b); pos_valid = 1'b1;
    t_send = cyc;
    @(posedge clk); #1;
    pos_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int budget = 6 * FRAME_LEN;
    while (fq.size() < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (fq.size() < n) check("frame_timeout", fq.size(), n);
  endtask

  task automatic do_frame(input string tag, input int p, input int m, input int b,
                          input logic [N-1:0] exp);
    fq.delete();
    send(p, m, b);
    wait_frames(1);
    if (fq.size() > 0) begin
      check({tag, "_pattern"}, fq[0].bits, exp);
      check({tag, "_rises"}, fq[0].rises, N);
      check({tag, "_le_len"}, fq[0].le_cycles, CDIV);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic count_oe_low(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (!oe) lows++;
    end
  endtask

  int dir_pos[9]  = '{18, 19, 40, 0, 5, 20, 2, 9, 4};
  int dir_mode[9] = '{0, 0, 0, 0, 2, 2, 3, 3, 1};
  logic [N-1:0] dir_exp[9] = '{16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0020,
                               16'h0000, 16'h03C0, 16'hFFFF, 16'h000F};

  initial begin
    int lows, idle0, le0, p, m, b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_led_clk", led_clk, 0);
    check("rst_sdi", sdi, 0);
    check("rst_le", le, 0);
    check("rst_oe", oe, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    check("oe_idle_before_frame", oe, 1);

    // First frame with timing: BIPOLAR pos=3 -> 0xFFFE.
    fq.delete();
    send(3, 0, 4);
    check("first_busy", busy, 1);
    check("first_sdi_msb", sdi, 1);
    wait_frames(1);
    if (fq.size() > 0) begin
      check("first_pattern", fq[0].bits, 16'hFFFE);
      check("first_rises", fq[0].rises, N);
      check("first_le_len", fq[0].le_cycles, CDIV);
      check("first_fd_cycle", fq[0].fd_cyc - t_send, FRAME_LEN);
      check("first_rise_cycle", fq[0].first_rise - t_send, 1 + CDIV);
    end
    repeat (4) @(posedge clk);
    check("busy_after_frame", busy, 0);
    count_oe_low(32, lows);
    check("oe_duty_b4", lows, 8);

    for (int i = 0; i < 9; i++)
      do_frame($sformatf("dir%0d", i), dir_pos[i], dir_mode[i], 4, dir_exp[i]);

    // Back-to-back: two overwrites while busy leave exactly one pending frame.
    fq.delete();
    send(20, 0, 4);
    idle0 = idle_cnt;
    repeat (10) @(posedge clk);
    send(21, 0, 4);
    repeat (10) @(posedge clk);
    send(22, 0, 4);
    wait_frames(2);
    check("pend_no_idle_gap", idle_cnt - idle0, 0);
    repeat (2 * FRAME_LEN) @(posedge clk);
    check("pend_frame_count", fq.size(), 2);
    if (fq.size() >= 2) begin
      check("pend_frame1", fq[0].bits, 16'h0003);
      check("pend_frame2", fq[1].bits, 16'h000F);
      check("pend_gap", fq[1].fd_cyc - fq[0].fd_cyc, FRAME_LEN);
    end

    // Brightness 0 blanks the chain.
    do_frame("b0", 4, 1, 0, 16'h000F);
    count_oe_low(32, lows);
    check("oe_b0", lows, 0);

    // Randomized frames against the model, with duty checked per frame.
    for (int i = 0; i < 20; i++) begin
      p = $urandom_range(0, 63);
      m = $urandom_range(0, 3);
      b = $urandom_range(0, 15);
      do_frame($sformatf("rnd%0d", i), p, m, b, ref_pattern(p, m));
      count_oe_low(32, lows);
      check($sformatf("rnd%0d_oe", i), lows, 2 * b);
    end

    // Reset during bit 7 of SHIFT aborts without any latch pulse.
    fq.delete();
    send(3, 0, 9);
    repeat (31) @(posedge clk);
    #1;
    rst = 1'b1;
    le0 = le_total;
    @(posedge clk); #1;
    check("abort_led_clk", led_clk, 0);
    check("abort_sdi", sdi, 0);
    check("abort_le", le, 0);
    check("abort_oe", oe, 1);
    check("abort_busy", busy, 0);
    check("abort_frame_done", frame_done, 0);
    rst = 1'b0;
    repeat (2 * FRAME_LEN) @(posedge clk);
    check("abort_no_le", le_total - le0, 0);
    check("abort_no_frame", fq.size(), 0);
    do_frame("post_abort", 19, 0, 4, 16'h0001);

    check("sdi_stable_high", sdi_glitch, 0);
    check("le_clk_overlap", le_clk_overlap, 0);
    check("oe_before_first_fd", oe_early, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
